fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the fetch PC, drives an in-order instruction-memory request/response port,

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the fetch PC, issues in-order requests on
//   the instruction-memory port, buffers returned words together with their
//   PC, and presents the buffer head to the fetch/decode pipeline register.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   stall_F               1 = decode stalled: hold the head, do not pop
//   redirect, redirect_pc taken branch/jump: flush and restart at redirect_pc
//   imem_req, imem_addr   request valid / 4-aligned byte address
//   imem_gnt              request accepted (imem_req & imem_gnt = handshake)
//   imem_rvalid/rdata     in-order response, >= 1 cycle after grant
//   instr_IF, PC_IF,      buffer head word / its PC / PC+4
//   PCPlus4_IF            (NOP_INSTR, 0, 0 when the buffer is empty)
//   valid_IF              1 = head holds a real fetched instruction
//
// Handshakes: a request transfers on a cycle with imem_req & imem_gnt; a
// response transfers on any cycle with imem_rvalid (no back-pressure). The
// credit check (outstanding + buffered < FIFO_DEPTH) guarantees every
// response has a buffer slot, so the response port never needs to stall.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_IF,
    output logic [31:0] PC_IF,
    output logic [31:0] PCPlus4_IF,
    output logic        valid_IF
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill_cnt;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] tag_wr;

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   tag_pc    [FIFO_DEPTH];

    logic          grant;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [CW:0]   credit_used;
    logic [CW-1:0] outstanding_nxt;

    always_comb begin
        credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
        credit_ok       = credit_used < (CW + 1)'(FIFO_DEPTH);
        imem_req        = (state == FETCH) && credit_ok && !redirect;
        imem_addr       = fetch_pc;
        grant           = imem_req && imem_gnt;
        // A response in a redirect cycle (or while draining) belongs to a
        // killed request and is never buffered.
        push            = (state == FETCH) && imem_rvalid && !redirect;
        valid_IF        = (fifo_count != '0);
        pop             = valid_IF && !stall_F && !redirect;
        outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);
        instr_IF        = valid_IF ? fifo_data[rd_ptr] : NOP_INSTR;
        PC_IF           = valid_IF ? fifo_pc[rd_ptr] : 32'h0;
        PCPlus4_IF      = valid_IF ? fifo_pc[rd_ptr] + 32'd4 : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            kill_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;

            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            // PC tags of in-flight requests; killed requests need no tag.
            if (redirect) begin
                tag_rd <= '0;
                tag_wr <= '0;
            end else begin
                if (grant) tag_wr <= tag_wr + PW'(1);
                if (push)  tag_rd <= tag_rd + PW'(1);
            end

            if (redirect) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end

            case (state)
                BOOT:  state <= FETCH;
                FETCH: begin
                    // outstanding_nxt already includes this cycle's grant
                    // and any response consumed in the redirect cycle.
                    if (redirect && (outstanding_nxt != '0)) begin
                        state    <= DRAIN;
                        kill_cnt <= outstanding_nxt;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        kill_cnt <= kill_cnt - CW'(1);
                        if (kill_cnt == CW'(1)) state <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Storage carries no reset: entries are only read when marked valid.
    always_ff @(posedge clk) begin
        if (grant) tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
        end
    end

    a_fifo_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with an in-order memory responder and a
//   queue-based model of the fetch stage (PCs waiting in the buffer, PCs in
//   flight, kill count). Every cycle the DUT outputs are compared with the
//   model; literal checks pin the model at the interesting points.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          D        = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_F;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_IF;
    logic [31:0] PC_IF;
    logic [31:0] PCPlus4_IF;
    logic        valid_IF;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(D),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_F    (stall_F),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_IF   (instr_IF),
        .PC_IF      (PC_IF),
        .PCPlus4_IF (PCPlus4_IF),
        .valid_IF   (valid_IF)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mem_lat = 1;

    // ---------------- memory responder state ----------------
    logic [31:0] rsp_addr_q[$];
    int          rsp_due_q[$];
    logic [31:0] grant_log[$];

    // ---------------- model state ----------------
    int          m_mode;      // 0 boot, 1 fetching, 2 draining
    logic [31:0] m_pc;
    int          m_out;
    int          m_kill;
    logic [31:0] m_tags[$];   // PCs of requests in flight
    logic [31:0] exp_q[$];    // PCs buffered, head first

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RESET_PC;
        m_out  = 0;
        m_kill = 0;
        m_tags.delete();
        exp_q.delete();
        rsp_addr_q.delete();
        rsp_due_q.delete();
        grant_log.delete();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, valid_IF}, 32'd0);
        check({tag, "_instr"}, instr_IF, NOP);
        check({tag, "_pc"},    PC_IF, 32'd0);
        check({tag, "_pc4"},   PCPlus4_IF, 32'd0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall_F     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: present the memory response, compare the DUT with the
    // model, advance model and memory across the rising edge.
    task automatic step();
        logic        exp_req, exp_valid, g, rv, dut_grant;
        logic [31:0] addr_cap;
        int          old_mode;
        imem_rvalid = (rsp_due_q.size() > 0) && (rsp_due_q[0] <= cyc);
        imem_rdata  = imem_rvalid ? word(rsp_addr_q[0]) : 32'h0;
        #1;
        exp_req   = (m_mode == 1) && (m_out + exp_q.size() < D) && !redirect;
        exp_valid = exp_q.size() > 0;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("valid_IF", {31'b0, valid_IF}, {31'b0, exp_valid});
        check("PC_IF", PC_IF, exp_valid ? exp_q[0] : 32'h0);
        check("PCPlus4_IF", PCPlus4_IF, exp_valid ? exp_q[0] + 32'd4 : 32'h0);
        check("instr_IF", instr_IF, exp_valid ? word(exp_q[0]) : NOP);

        g        = exp_req && imem_gnt;
        rv       = imem_rvalid;
        old_mode = m_mode;
        if (exp_valid && !stall_F && !redirect) void'(exp_q.pop_front());
        if (rv && old_mode == 1 && !redirect && m_tags.size() > 0)
            exp_q.push_back(m_tags.pop_front());
        if (g) begin
            m_tags.push_back(m_pc);
            m_pc = m_pc + 32'd4;
            m_out++;
        end
        if (rv) m_out--;
        case (old_mode)
            0: m_mode = 1;
            1: if (redirect && m_out > 0) begin
                   m_mode = 2;
                   m_kill = m_out;
               end
            default: if (rv) begin
                   m_kill--;
                   if (m_kill == 0) m_mode = 1;
               end
        endcase
        if (redirect) begin
            exp_q.delete();
            m_tags.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end

        dut_grant = imem_req && imem_gnt;
        addr_cap  = imem_addr;
        @(posedge clk);
        if (rv && rsp_addr_q.size() > 0) begin
            void'(rsp_addr_q.pop_front());
            void'(rsp_due_q.pop_front());
        end
        if (dut_grant) begin
            rsp_addr_q.push_back(addr_cap);
            rsp_due_q.push_back(cyc + mem_lat);
            grant_log.push_back(addr_cap);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          i;
        logic [31:0] held;
        logic        seen;
        int          k;

        // ---------- 1: reset release, streaming fetch ----------
        do_reset();
        imem_gnt = 1'b1;
        mem_lat  = 1;
        #1 check("t1_boot_req", {31'b0, imem_req}, 32'd0);
        step();
        #1 check("t1_req1", {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        step();
        #1 check("t1_addr4", imem_addr, 32'h4);
        step();
        #1 check("t1_valid3", {31'b0, valid_IF}, 32'd1);
        check("t1_pc0", PC_IF, 32'h0);
        check("t1_pc4_0", PCPlus4_IF, 32'h4);
        check("t1_instr0", instr_IF, word(32'h0));
        step();
        repeat (8) step();

        // ---------- 2: stall with a full buffer ----------
        i = 0;
        while (!valid_IF && i < 10) begin step(); i++; end
        check("t2_valid_before_stall", {31'b0, valid_IF}, 32'd1);
        held    = PC_IF;
        stall_F = 1'b1;
        step();
        step();
        #1 check("t2_req_off", {31'b0, imem_req}, 32'd0);
        check("t2_held_pc", PC_IF, held);
        step();
        stall_F = 1'b0;
        step();
        #1 check("t2_next_pc", PC_IF, held + 32'd4);
        check("t2_next_valid", {31'b0, valid_IF}, 32'd1);
        repeat (4) step();

        // ---------- 3: redirect with two requests outstanding ----------
        do_reset();
        imem_gnt = 1'b1;
        mem_lat  = 3;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        i = 0;
        #1;
        while (!imem_req && i < 20) begin step(); i++; #1; end
        check("t3_drain_cycles", i, 2);
        check("t3_addr", imem_addr, 32'h100);
        i = 0;
        while (!valid_IF && i < 20) begin step(); i++; #1; end
        check("t3_first_pc", PC_IF, 32'h100);

        // ---------- 4/5: redirect + gnt + rvalid together, unaligned target ----------
        do_reset();
        imem_gnt = 1'b1;
        mem_lat  = 2;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect = 1'b0;
        i = 0;
        #1;
        while (!imem_req && i < 20) begin step(); i++; #1; end
        check("t4_drain_cycles", i, 1);
        check("t5_aligned_addr", imem_addr, 32'h200);
        i = 0;
        while (!valid_IF && i < 20) begin step(); i++; #1; end
        check("t4_first_pc", PC_IF, 32'h200);
        check("t4_first_instr", instr_IF, word(32'h200));

        // ---------- 5: address wrap ----------
        do_reset();
        imem_gnt    = 1'b1;
        mem_lat     = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        seen     = 1'b0;
        for (int n = 0; n < 12; n++) begin
            #1;
            if (valid_IF && PC_IF == 32'hFFFF_FFFC) begin
                check("t5_pc4_wrap", PCPlus4_IF, 32'h0);
                seen = 1'b1;
            end
            step();
        end
        check("t5_seen_top", {31'b0, seen}, 32'd1);
        k = -1;
        for (int n = 0; n + 1 < grant_log.size(); n++)
            if (grant_log[n] == 32'hFFFF_FFFC && k < 0) k = n;
        check("t5_found_top_grant", {31'b0, k >= 0}, 32'd1);
        if (k >= 0) check("t5_addr_wrap", grant_log[k + 1], 32'h0);

        // ---------- 6: asynchronous reset in the middle of a drain ----------
        do_reset();
        imem_gnt = 1'b1;
        mem_lat  = 4;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        step();
        #2 rst = 1'b1;
        #1 reset_checks("t6_async");
        imem_rvalid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        step();
        #1 check("t6_req", {31'b0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, RESET_PC);
        repeat (4) step();

        // ---------- 7: mixed traffic ----------
        do_reset();
        for (int n = 0; n < 200; n++) begin
            imem_gnt    = ($urandom_range(0, 3) != 0);
            stall_F     = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            mem_lat     = $urandom_range(1, 3);
            step();
        end
        redirect = 1'b0;
        stall_F  = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
